// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the UART_Top-facing drain handshake and the host-facing FWFT
//   queue port of uart_rx_fifo.
//   slave  : view taken by uart_rx_fifo (consumes rxrdy/rx data, rd_en,
//            flush; drives read, head entry, level flags).
//   master : view taken by whatever drives the block (UART side + host).
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    // UART_Top side
    logic              rxrdy;
    logic [7:0]        rx_data;
    logic              parityerr;
    logic              framingerr;
    logic              overrun;
    logic              read;
    // host side
    logic              rd_en;
    logic              flush;
    logic [7:0]        dout;
    logic              dout_perr;
    logic              dout_ferr;
    logic              dout_ovr;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              irq;

    modport slave (
        input  rxrdy, rx_data, parityerr, framingerr, overrun, rd_en, flush,
        output read, dout, dout_perr, dout_ferr, dout_ovr, empty, full, count, irq
    );

    modport master (
        output rxrdy, rx_data, parityerr, framingerr, overrun, rd_en, flush,
        input  read, dout, dout_perr, dout_ferr, dout_ovr, empty, full, count, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Drains received bytes plus their error status out of UART_Top into a
//   circular first-word-fall-through queue for the host.
//   Ports:
//     clk  - system clock
//     rst  - synchronous, active-low reset
//     bus  - uart_rx_fifo_if.slave: rxrdy/rx_data/parityerr/framingerr/
//            overrun in, read pulse out; rd_en/flush in, head entry
//            (dout, dout_perr, dout_ferr, dout_ovr), empty, full, count,
//            irq out.
//   Entry layout: {overrun, framingerr, parityerr, rx_data}.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for rxrdy with room in the queue
//   RD    | read pulse high; entry captured and written at closing edge
//   WAIT  | byte consumed; wait for rxrdy to drop before re-arming
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int IRQ_LEVEL = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_fifo_if.slave     bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] IRQ_CNT  = (ADDR_W + 1)'(IRQ_LEVEL);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              irq_q, irq_d;
    logic [10:0]       mem_q [DEPTH];

    logic              push;
    logic              pop;
    logic              is_empty;
    logic [10:0]       entry;
    logic [10:0]       head;

    // RD is only entered when not full, and only this block pushes, so no
    // second full check is needed here.
    assign push     = (state_q == ST_RD);
    assign is_empty = (count_q == '0);
    assign pop      = bus.rd_en && !is_empty;
    assign entry    = {bus.overrun, bus.framingerr, bus.parityerr, bus.rx_data};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.rxrdy && (count_q != FULL_CNT)) state_d = ST_RD;
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: if (!bus.rxrdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Flush clears the queue but leaves the drain FSM alone, so a byte being
    // captured in RD is dropped yet still acknowledged and not re-read.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        irq_d = (count_d >= IRQ_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Storage needs no reset: contents are only visible through the head
    // mux, which is gated by empty.
    always_ff @(posedge clk) begin
        if (rst && push && !bus.flush) mem_q[wr_ptr_q] <= entry;
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.read  = (state_q == ST_RD);
    assign bus.count = count_q;
    assign bus.empty = is_empty;
    assign bus.full  = (count_q == FULL_CNT);
    assign bus.irq   = irq_q;
    assign {bus.dout_ovr, bus.dout_ferr, bus.dout_perr, bus.dout} =
        is_empty ? 11'd0 : head;
endmodule
